// File: rtl/plot_pkg.sv
// plot_pkg
// Shared definitions for the pixel-plot sink: screen geometry, framebuffer
// address width, colour width, the packed pixel record carried through the
// FIFO, and the linear-address helper used by the write port.
package plot_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_AW    = 15;
  localparam int COLOUR_W = 3;

  typedef struct packed {
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // y*160 + x built from two shifts, so no multiplier is needed. The
  // largest on-screen result is 19199, which fits in FB_AW bits.
  function automatic logic [FB_AW-1:0] fb_address(input logic [7:0] px,
                                                  input logic [6:0] py);
    logic [FB_AW-1:0] ye;
    ye = {8'd0, py};
    return (ye << 7) + (ye << 5) + {7'd0, px};
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// plot_fifo
// Synchronous FIFO with registered occupancy.
//   clk, resetn : clock, asynchronous active-low reset
//   push, wdata : write request and data (ignored while full)
//   pop, rdata  : read request (ignored while empty) and head-of-queue data
//   level       : current occupancy, 0..DEPTH
//   full, empty : decoded from the registered level only
module plot_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two. A push and a
  // pop on the same edge leave level unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/plot_sink.sv
// plot_sink
// Receives plot commands from the sprite drawers, drops off-screen pixels,
// queues the rest and drains them into the framebuffer write port.
//   CLOCK_50, resetn       : clock, asynchronous active-low reset
//   x, y, colour, plot     : incoming plot command
//   ready                  : FIFO can accept a pixel this edge
//   fb_busy                : framebuffer port unavailable (stalls the pop)
//   fb_addr/fb_data/fb_wren: registered framebuffer write
//   level                  : FIFO occupancy
//   drop_oob, drop_ovf     : saturating drop counters (off-screen / full)
module plot_sink
  import plot_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic [7:0]            x,
  input  logic [6:0]            y,
  input  logic [COLOUR_W-1:0]   colour,
  input  logic                  plot,
  output logic                  ready,
  input  logic                  fb_busy,
  output logic [FB_AW-1:0]      fb_addr,
  output logic [COLOUR_W-1:0]   fb_data,
  output logic                  fb_wren,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]            drop_oob,
  output logic [7:0]            drop_ovf
);

  pixel_t in_pix;
  pixel_t head;
  logic   in_range;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;
  logic   oob_hit;
  logic   ovf_hit;

  assign in_pix   = '{x: x, y: y, colour: colour};
  // Range check wins over fullness, so an off-screen pixel is never
  // counted as an overflow drop.
  assign in_range = (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
  assign ready    = !full;
  assign push     = plot && in_range && ready;
  assign oob_hit  = plot && !in_range;
  assign ovf_hit  = plot && in_range && !ready;
  assign pop      = !empty && !fb_busy;

  plot_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(pixel_t))
  ) u_fifo (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (in_pix),
    .rdata  (head),
    .level  (level),
    .full   (full),
    .empty  (empty)
  );

  // Drop counters stick at 255 and only clear on reset.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      drop_oob <= '0;
      drop_ovf <= '0;
    end else begin
      if (oob_hit && drop_oob != 8'hFF) drop_oob <= drop_oob + 8'd1;
      if (ovf_hit && drop_ovf != 8'hFF) drop_ovf <= drop_ovf + 8'd1;
    end
  end

  // Output register: the strobe follows pop every edge, while address and
  // data hold their last written values between strobes.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      fb_wren <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_wren <= pop;
      if (pop) begin
        fb_addr <= fb_address(head.x, head.y);
        fb_data <= head.colour;
      end
    end
  end

endmodule

// File: tb/tb_plot_sink.sv
// tb_plot_sink
// Self-checking bench for plot_sink: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_plot_sink;
  import plot_pkg::*;

  localparam int DEPTH = 8;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic [7:0]  x        = '0;
  logic [6:0]  y        = '0;
  logic [2:0]  colour   = '0;
  logic        plot     = 1'b0;
  logic        fb_busy  = 1'b0;
  logic        ready;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_wren;
  logic [3:0]  level;
  logic [7:0]  drop_oob;
  logic [7:0]  drop_ovf;

  plot_sink #(.DEPTH(DEPTH)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .ready    (ready),
    .fb_busy  (fb_busy),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_wren  (fb_wren),
    .level    (level),
    .drop_oob (drop_oob),
    .drop_ovf (drop_ovf)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a plain queue of accepted pixels plus expected outputs.
  pixel_t mq[$];
  int     exp_wren = 0;
  int     exp_addr = 0;
  int     exp_data = 0;
  int     exp_oob  = 0;
  int     exp_ovf  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("fb_wren",  32'(fb_wren),  32'(exp_wren));
    checkOutput("fb_addr",  32'(fb_addr),  32'(exp_addr));
    checkOutput("fb_data",  32'(fb_data),  32'(exp_data));
    checkOutput("level",    32'(level),    32'(mq.size()));
    checkOutput("ready",    32'(ready),    32'(mq.size() != DEPTH));
    checkOutput("drop_oob", 32'(drop_oob), 32'(exp_oob));
    checkOutput("drop_ovf", 32'(drop_ovf), 32'(exp_ovf));
  endtask

  task automatic modelReset();
    mq.delete();
    exp_wren = 0;
    exp_addr = 0;
    exp_data = 0;
    exp_oob  = 0;
    exp_ovf  = 0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge occupancy.
  task automatic modelEdge(input bit p, input int px, input int py,
                           input int pc, input bit busy);
    int     pre;
    bit     can_take;
    pixel_t pix;
    pre      = mq.size();
    can_take = (pre != DEPTH);
    if (pre != 0 && !busy) begin
      pix      = mq.pop_front();
      exp_wren = 1;
      exp_addr = int'(pix.y) * SCREEN_W + int'(pix.x);
      exp_data = int'(pix.colour);
    end else begin
      exp_wren = 0;
    end
    if (p) begin
      if (px >= SCREEN_W || py >= SCREEN_H) begin
        if (exp_oob < 255) exp_oob++;
      end else if (!can_take) begin
        if (exp_ovf < 255) exp_ovf++;
      end else begin
        pix.x      = 8'(px);
        pix.y      = 7'(py);
        pix.colour = 3'(pc);
        mq.push_back(pix);
      end
    end
  endtask

  task automatic applyStimulus(input bit p, input int px, input int py,
                               input int pc, input bit busy);
    @(negedge CLOCK_50);
    plot    = p;
    x       = 8'(px);
    y       = 7'(py);
    colour  = 3'(pc);
    fb_busy = busy;
    @(posedge CLOCK_50);
    modelEdge(p, px, py, pc, busy);
    #1;
    checkAll();
  endtask

  task automatic idle(input int n, input bit busy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, busy);
  endtask

  task automatic checkResetState();
    checkOutput("rst_wren",  32'(fb_wren),  32'd0);
    checkOutput("rst_addr",  32'(fb_addr),  32'd0);
    checkOutput("rst_data",  32'(fb_data),  32'd0);
    checkOutput("rst_level", 32'(level),    32'd0);
    checkOutput("rst_ready", 32'(ready),    32'd1);
    checkOutput("rst_oob",   32'(drop_oob), 32'd0);
    checkOutput("rst_ovf",   32'(drop_ovf), 32'd0);
  endtask

  initial begin
    int px;
    int py;

    // Reset state while held in reset.
    #1;
    checkResetState();
    modelReset();
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;

    // Single pixel: strobe two edges after acceptance, exactly one cycle.
    applyStimulus(1'b1, 10, 5, 3'b101, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    checkOutput("single_wren", 32'(fb_wren), 32'd1);
    checkOutput("single_addr", 32'(fb_addr), 32'd810);
    checkOutput("single_data", 32'(fb_data), 32'd5);
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    checkOutput("single_once", 32'(fb_wren), 32'd0);

    // Corners and off-screen rejects.
    applyStimulus(1'b1, 0, 0, 1, 1'b0);
    applyStimulus(1'b1, 159, 119, 2, 1'b0);
    checkOutput("corner_lo", 32'(fb_addr), 32'd0);
    applyStimulus(1'b1, 160, 0, 3, 1'b0);
    checkOutput("corner_hi", 32'(fb_addr), 32'd19199);
    applyStimulus(1'b1, 0, 120, 4, 1'b0);
    idle(2, 1'b0);
    checkOutput("corner_oob", 32'(drop_oob), 32'd2);

    // Overflow: ten valid plots into a stalled FIFO.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, i * 13, i * 11, i, 1'b1);
    checkOutput("ovf_level", 32'(level),    32'd8);
    checkOutput("ovf_ready", 32'(ready),    32'd0);
    checkOutput("ovf_count", 32'(drop_ovf), 32'd2);
    idle(10, 1'b0);

    // Full with concurrent pop: plot every cycle while draining.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 100 + i, 50, i, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 20 + i, 60 + i, i, 1'b0);
    idle(10, 1'b0);

    // Stall mid-drain: busy toggles every cycle.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 30 * i, 25 * i, 7 - i, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0, 0, 0, (i % 2) == 0);

    // Randomized traffic with alternating light and heavy stall phases.
    for (int i = 0; i < 400; i++) begin
      px = ($urandom_range(0, 9) == 0) ? int'($urandom_range(160, 255))
                                       : int'($urandom_range(0, 159));
      py = ($urandom_range(0, 9) == 0) ? int'($urandom_range(120, 127))
                                       : int'($urandom_range(0, 119));
      applyStimulus($urandom_range(0, 3) != 0, px, py,
                    int'($urandom_range(0, 7)),
                    ((i / 50) % 2 == 1) ? ($urandom_range(0, 4) != 0)
                                        : ($urandom_range(0, 3) == 0));
    end
    idle(12, 1'b0);

    // Saturation of the off-screen counter.
    for (int i = 0; i < 260; i++) applyStimulus(1'b1, 200, 10, 0, 1'b0);
    checkOutput("oob_sat", 32'(drop_oob), 32'd255);

    // Reset mid-drain with level 5 and a write on the port.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 40 + i, 70, i, 1'b1);
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    checkOutput("pre_rst_lvl", 32'(level), 32'd5);
    #2;
    resetn = 1'b0;
    #1;
    modelReset();
    checkResetState();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    idle(6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
